// File: rtl/im_loader.sv
// im_loader: boot-time instruction-memory writer.
// Takes a byte stream over valid/ready. The first two bytes are a 16-bit
// little-endian word count. The data bytes that follow are packed into
// little-endian 32-bit words and written to consecutive IM word addresses.
// The CPU core is held in reset until the whole image has been written.
module im_loader #(
  parameter  int DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [7:0]    byte_in,
  input  logic          byte_valid,
  output logic          byte_ready,
  output logic          im_we,
  output logic [AW-1:0] im_waddr,
  output logic [31:0]   im_wdata,
  output logic [AW:0]   word_cnt,
  output logic          done,
  output logic          err,
  output logic          cpu_rst_n
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR0  = 3'd1,
    HDR1  = 3'd2,
    DATA  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_t;

  state_t        state_r;
  state_t        state_n_s;
  logic [7:0]    len_lo_r;
  logic [15:0]   length_r;
  logic [1:0]    byte_idx_r;
  logic [31:0]   wdata_r;
  logic [AW-1:0] waddr_r;
  logic [AW:0]   word_cnt_r;

  logic          xfer_s;
  logic [15:0]   hdr_len_s;
  logic          hdr_bad_s;
  logic          last_word_s;

  // Every output is decoded from the state register or is a register itself,
  // so no input reaches an output within the same cycle.
  assign byte_ready = (state_r == HDR0) || (state_r == HDR1) || (state_r == DATA);
  assign im_we      = (state_r == WRITE);
  assign done       = (state_r == DONE);
  assign err        = (state_r == ERR);
  assign cpu_rst_n  = (state_r == DONE);
  assign im_waddr   = waddr_r;
  assign im_wdata   = wdata_r;
  assign word_cnt   = word_cnt_r;

  assign xfer_s      = byte_valid && byte_ready;
  assign hdr_len_s   = {byte_in, len_lo_r};
  // Length is unsigned 16-bit; only 1..DEPTH is a loadable image.
  assign hdr_bad_s   = (hdr_len_s == 16'd0) || (hdr_len_s > 16'(DEPTH));
  assign last_word_s = ((16'(word_cnt_r) + 16'd1) == length_r);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Next-state logic; start is only honoured while no load is in flight.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_n_s = HDR0;
        else       state_n_s = IDLE;
      end
      HDR0: begin
        if (xfer_s) state_n_s = HDR1;
        else        state_n_s = HDR0;
      end
      HDR1: begin
        if (xfer_s && hdr_bad_s) state_n_s = ERR;
        else if (xfer_s)         state_n_s = DATA;
        else                     state_n_s = HDR1;
      end
      DATA: begin
        if (xfer_s && (byte_idx_r == 2'd3)) state_n_s = WRITE;
        else                                state_n_s = DATA;
      end
      WRITE: begin
        if (last_word_s) state_n_s = DONE;
        else             state_n_s = DATA;
      end
      DONE: begin
        if (start) state_n_s = HDR0;
        else       state_n_s = DONE;
      end
      ERR: begin
        if (start) state_n_s = HDR0;
        else       state_n_s = ERR;
      end
      default: state_n_s = IDLE;
    endcase
  end

  // Datapath: header capture, byte packing, address and word counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_lo_r   <= 8'd0;
      length_r   <= 16'd0;
      byte_idx_r <= 2'd0;
      wdata_r    <= 32'd0;
      waddr_r    <= '0;
      word_cnt_r <= '0;
    end else begin
      case (state_r)
        IDLE, DONE, ERR: begin
          if (start) begin
            byte_idx_r <= 2'd0;
            wdata_r    <= 32'd0;
            waddr_r    <= '0;
            word_cnt_r <= '0;
          end
        end
        HDR0: begin
          if (xfer_s) len_lo_r <= byte_in;
        end
        HDR1: begin
          if (xfer_s) length_r <= hdr_len_s;
        end
        DATA: begin
          if (xfer_s) begin
            wdata_r[{byte_idx_r, 3'b000} +: 8] <= byte_in;
            byte_idx_r <= byte_idx_r + 2'd1;
          end
        end
        WRITE: begin
          word_cnt_r <= word_cnt_r + 1'b1;
          // Keep the final address on the bus rather than wrapping past the top.
          if (!last_word_s) waddr_r <= waddr_r + 1'b1;
        end
        default: begin
          byte_idx_r <= byte_idx_r;
        end
      endcase
    end
  end

endmodule

// File: doc/im_loader.md
# im_loader

Boot-time writer for the 4 KiB instruction memory. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words and issues one write per word into the IM write port at consecutive word addresses. It holds the CPU core in reset until the programmed image is complete. It sits between the host/serial front end and the instruction memory. The IM fetch side stays read-only and PC-indexed (`pc[11:2]`).

## Interface
Parameters:
- `DEPTH`, default 1024: IM depth in words. `waddr` width is log2(`DEPTH`) = 10.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle pulse that begins a load. Honoured only in IDLE, DONE and ERR.
- `byte_in`, in, 8: stream byte.
- `byte_valid`, in, 1: `byte_in` is valid.
- `byte_ready`, out, 1: the loader accepts `byte_in` this cycle.
- `im_we`, out, 1: IM write enable, one-cycle pulse per word.
- `im_waddr`, out, 10: IM word address.
- `im_wdata`, out, 32: IM write data.
- `word_cnt`, out, 11: number of words written so far in the current load.
- `done`, out, 1: image fully written.
- `err`, out, 1: the header was illegal.
- `cpu_rst_n`, out, 1: active-low reset to the core. It is low except in DONE.

## Operation
- **Stream format.** Byte 0 is length[7:0]. Byte 1 is length[15:8]. These are followed by length×4 data bytes. Each word is least-significant byte first.
- **States and transitions.**
  - IDLE: `start` → HDR0.
  - HDR0: accept byte → HDR1.
  - HDR1: accept byte → check the length.
    - length = 0 or length > `DEPTH` → ERR.
    - Otherwise → DATA.
  - DATA: accept bytes into a 2-bit byte index.
    - On the 4th byte → WRITE.
  - WRITE: pulse `im_we`.
    - If `word_cnt`+1 == length → DONE.
    - Otherwise → DATA.
  - DONE and ERR: `start` → HDR0. Both are otherwise sticky.
- **Transfer rule.** A byte is transferred only on a rising edge where `byte_valid` && `byte_ready`. `byte_valid` without `byte_ready` is ignored. Nothing is dropped or duplicated.
- **`byte_ready`.** Equals 1 exactly in HDR0, HDR1 and DATA.
- **Word assembly.** Byte k of a word (k = 0..3) goes to `im_wdata`[8k+7:8k].
- **Addressing.** `im_waddr` starts at 0 for each load and increments by 1 after each WRITE. `word_cnt` equals the number of completed writes.
- **Length width.** Length is held as 16 bits and compared unsigned. Bits above 10 are legal only as part of the values 1..1024. For example, 0x0400 is legal and 0x0401 is an error.
- **Restart.** `start` in DONE or ERR clears `done`, `err`, `word_cnt`, `im_waddr` and the byte index, and drives `cpu_rst_n` low on the next cycle.
- **Ignored `start`.** `start` during HDR0, HDR1, DATA or WRITE is ignored.

## Timing
- **Reset.** Asynchronous assertion of `rst_n`=0 forces immediately:
  - state IDLE;
  - `byte_ready`=0, `im_we`=0, `im_waddr`=0, `im_wdata`=0;
  - `word_cnt`=0, `done`=0, `err`=0, `cpu_rst_n`=0.
  
  Reset mid-load abandons the load. Words already written stay in the IM, and no further `im_we` is issued.
- **Outputs.** All outputs are registered, or decoded from registered state only. There are no combinational paths from inputs to outputs.
- **Start latency.** `start` sampled at edge E → HDR0 and `byte_ready`=1 after E.
- **Write latency.** The 4th byte of a word accepted at edge N → `im_we`=1 during cycle N..N+1, with `im_waddr` and `im_wdata` stable. `byte_ready`=0 in that cycle. `byte_ready` returns to 1 after edge N+1 unless the word was the last.
- **IM write timing.** The IM samples the write at edge N+1.
- **Completion.** After the last WRITE, at edge N+1: `done`=1 and `cpu_rst_n`=1.
- **Error.** The 2nd header byte accepted at edge H with an illegal length → `err`=1 and `byte_ready`=0 after H.
- **Throughput.** Peak rate is 4 bytes per 5 cycles.
- **Back-pressure.** The loader stalls indefinitely on `byte_valid`=0 with no timeout. Gaps between bytes within a word are legal.

## Test plan
- **Reset values.** Assert `rst_n`=0 mid-cycle → every output takes its reset value without waiting for a clock edge, including `cpu_rst_n`=0 and `byte_ready`=0.
- **Single-word load.** `start`, then bytes 01 00 78 56 34 12, continuously valid → exactly one `im_we` with `im_waddr`=0 and `im_wdata`=0x12345678. Then `done`=1, `cpu_rst_n`=1, `word_cnt`=1.
- **Full-depth load.**
  - Length 0x0400 followed by 4096 bytes with random `byte_valid` gaps → 1024 writes with addresses 0..1023 in order.
  - `im_wdata` matches the reference words.
  - The last write is at address 1023, with no wrap to 0.
  - `done`=1.
- **Illegal lengths.** Length 0x0000 → `err`=1 and no `im_we`. Repeat with 0x0401 → `err`=1. Then `start` and a valid 1-word stream → `err`=0, then `done`=1.
- **Handshake hold.** Hold `byte_valid`=1 during the WRITE cycle with a new byte present → that byte is not consumed. It is accepted on the next cycle as byte 0 of the next word.
- **Reset mid-load, and ignored start.**
  - Assert `rst_n` after 2 of 3 words → IDLE, `cpu_rst_n`=0, no 3rd write.
  - A `start` pulse during DATA is ignored: the same load completes normally.
